// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative shift-add multiply / restoring divide
// sequencer owning the HI/LO register pair.
`timescale 1ns/1ps
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic             hi_rd,
  input  logic             lo_rd,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             stall
);

  localparam int W  = WIDTH;
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [CW-1:0]  cnt_q;
  logic           div_q;
  logic           neg_q;
  logic           rneg_q;
  logic           dz_q;
  logic [W-1:0]   rs_q;
  logic [2*W-1:0] a_q;
  logic [W-1:0]   b_q;
  logic [2*W-1:0] p_q;
  logic [W-1:0]   hi_q, lo_q;
  logic [W-1:0]   hi_d, lo_d;
  logic           hi_we, lo_we;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  logic           sgn;
  logic           sa, sb;
  logic [W-1:0]   ma, mb;
  logic [W:0]     upper;
  logic [W:0]     diff;
  logic           ge;
  logic [2*W-1:0] div_nxt;
  logic [2*W-1:0] prod;
  logic [W-1:0]   quot, rem;

  // Operand magnitudes and sign flags for the capture edge
  always_comb begin
    sgn = ~op[0];
    sa  = sgn & rs_data[W-1];
    sb  = sgn & rt_data[W-1];
    ma  = sa ? (-rs_data) : rs_data;
    mb  = sb ? (-rt_data) : rt_data;
  end

  // One restoring-divide step: {rem,quot} shifts left, trial subtract
  always_comb begin
    upper   = a_q[2*W-1:W-1];
    ge      = upper >= {1'b0, b_q};
    diff    = upper - {1'b0, b_q};
    div_nxt = ge ? {diff[W-1:0], a_q[W-2:0], 1'b1}
                 : {a_q[2*W-2:0], 1'b0};
  end

  // State register and registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN:  if (cnt_q == CW'(W-1)) state_d = FIX;
      FIX:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: status, stall and the HI/LO write port
  always_comb begin
    busy_d = (state_d != IDLE);
    done_d = (state_q == FIX);
    stall  = busy_q & (start | mthi | mtlo | hi_rd | lo_rd);
    prod   = neg_q ? (-p_q) : p_q;
    quot   = neg_q ? (-a_q[W-1:0]) : a_q[W-1:0];
    rem    = rneg_q ? (-a_q[2*W-1:W]) : a_q[2*W-1:W];
    hi_d   = hi_q;
    lo_d   = lo_q;
    hi_we  = 1'b0;
    lo_we  = 1'b0;
    if (state_q == FIX) begin
      hi_we = 1'b1;
      lo_we = 1'b1;
      if (!div_q) begin
        hi_d = prod[2*W-1:W];
        lo_d = prod[W-1:0];
      end else if (dz_q) begin
        hi_d = rs_q;
        lo_d = '1;
      end else begin
        hi_d = rem;
        lo_d = quot;
      end
    end else if (state_q == IDLE && !start) begin
      hi_we = mthi;
      lo_we = mtlo;
      hi_d  = rs_data;
      lo_d  = rs_data;
    end
  end

  // Iteration datapath: capture on start, one step per RUN cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      div_q  <= 1'b0;
      neg_q  <= 1'b0;
      rneg_q <= 1'b0;
      dz_q   <= 1'b0;
      rs_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      p_q    <= '0;
    end else if (state_q == IDLE && start) begin
      cnt_q  <= '0;
      div_q  <= op[1];
      neg_q  <= sa ^ sb;
      rneg_q <= sa;
      dz_q   <= op[1] & (rt_data == '0);
      rs_q   <= rs_data;
      a_q    <= {{W{1'b0}}, ma};
      b_q    <= mb;
      p_q    <= '0;
    end else if (state_q == RUN) begin
      cnt_q <= cnt_q + 1'b1;
      if (div_q) begin
        a_q <= div_nxt;
      end else begin
        p_q <= p_q + (b_q[0] ? a_q : '0);
        a_q <= a_q << 1;
        b_q <= b_q >> 1;
      end
    end
  end

  // Architectural HI/LO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      if (hi_we) hi_q <= hi_d;
      if (lo_we) lo_q <= lo_d;
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed vector table plus hand sequences
// for move, stall, ignored-request and mid-run reset cases.
`timescale 1ns/1ps
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_data, rt_data;
  logic        mthi, mtlo, hi_rd, lo_rd;
  logic [31:0] hi, lo;
  logic        busy, done, stall;

  int nvec  = 0;
  int nmiss = 0;

  muldiv_seq #(.WIDTH(32)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .op      (op),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .mthi    (mthi),
    .mtlo    (mtlo),
    .hi_rd   (hi_rd),
    .lo_rd   (lo_rd),
    .hi      (hi),
    .lo      (lo),
    .busy    (busy),
    .done    (done),
    .stall   (stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] ehi;
    logic [31:0] elo;
    int          hird;
    int          junk;
  } vec_t;

  localparam logic [1:0] MULT  = 2'b00;
  localparam logic [1:0] MULTU = 2'b01;
  localparam logic [1:0] DIV   = 2'b10;
  localparam logic [1:0] DIVU  = 2'b11;

  vec_t tbl[13];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmiss++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Entered and left at a negedge; consecutive calls are back-to-back.
  task automatic do_op(input string nm, input vec_t v);
    int  nb;
    int  serr;
    bit  got;
    logic exp_st;
    start   = 1'b1;
    op      = v.op;
    rs_data = v.rs;
    rt_data = v.rt;
    #1;
    chk({nm, "_stall_idle"}, {31'd0, stall}, 32'd0);
    @(posedge clk);
    #1 start = 1'b0;
    nb   = 0;
    serr = 0;
    got  = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
      if (i == v.hird) hi_rd = 1'b1;
      if (i == v.junk) begin
        start   = 1'b1;
        mtlo    = 1'b1;
        op      = MULTU;
        rs_data = 32'd5;
        rt_data = 32'd5;
      end
      if (v.junk >= 0 && i == v.junk + 1) begin
        start = 1'b0;
        mtlo  = 1'b0;
      end
      #1;
      exp_st = (v.hird >= 0 && i >= v.hird) || (i == v.junk);
      if (stall !== exp_st) serr++;
      if (busy) nb++;
    end
    #1;
    chk({nm, "_done_seen"}, {31'd0, got}, 32'd1);
    chk({nm, "_busy_cycles"}, nb, 32'd33);
    chk({nm, "_stall_run_errs"}, serr, 32'd0);
    chk({nm, "_hi"}, hi, v.ehi);
    chk({nm, "_lo"}, lo, v.elo);
    if (v.hird >= 0) begin
      chk({nm, "_stall_done"}, {31'd0, stall}, 32'd0);
      hi_rd = 1'b0;
    end
  endtask

  initial begin
    tbl[0]  = '{MULT,  32'hFFFFFFFD, 32'd7,
                32'hFFFFFFFF, 32'hFFFFFFEB, -1, -1};
    tbl[1]  = '{MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF,
                32'hFFFFFFFE, 32'h00000001, -1, -1};
    tbl[2]  = '{MULT,  32'hFFFFFFFF, 32'hFFFFFFFF,
                32'h00000000, 32'h00000001, -1, -1};
    tbl[3]  = '{DIV,   32'hFFFFFFF9, 32'd2,
                32'hFFFFFFFF, 32'hFFFFFFFD, -1, -1};
    tbl[4]  = '{DIVU,  32'd100, 32'd0,
                32'h00000064, 32'hFFFFFFFF, -1, -1};
    tbl[5]  = '{DIV,   32'h80000000, 32'hFFFFFFFF,
                32'h00000000, 32'h80000000, -1, -1};
    tbl[6]  = '{DIV,   32'd7, 32'hFFFFFFFE,
                32'h00000001, 32'hFFFFFFFD, -1, -1};
    tbl[7]  = '{DIV,   32'hFFFFFF9C, 32'd0,
                32'hFFFFFF9C, 32'hFFFFFFFF, -1, -1};
    tbl[8]  = '{MULT,  32'h80000000, 32'h80000000,
                32'h40000000, 32'h00000000, -1, -1};
    tbl[9]  = '{MULT,  32'h12345678, 32'h00000010,
                32'h00000001, 32'h23456780, -1, -1};
    tbl[10] = '{MULTU, 32'd6, 32'd7,
                32'h00000000, 32'd42, 4, -1};
    tbl[11] = '{DIVU,  32'd100, 32'd7,
                32'd2, 32'd14, -1, 3};
    tbl[12] = '{DIV,   32'd0, 32'd5,
                32'd0, 32'd0, -1, -1};

    rst_n   = 1'b0;
    start   = 1'b0;
    op      = 2'b00;
    rs_data = '0;
    rt_data = '0;
    mthi    = 1'b0;
    mtlo    = 1'b0;
    hi_rd   = 1'b0;
    lo_rd   = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    mthi    = 1'b1;
    rs_data = 32'h12345678;
    #1 chk("mthi_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    chk("mthi_hi", hi, 32'h12345678);
    chk("mthi_lo", lo, 32'd0);
    mthi    = 1'b0;
    mtlo    = 1'b1;
    rs_data = 32'h9ABCDEF0;
    #1 chk("mtlo_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    mtlo = 1'b0;
    chk("mtlo_lo", lo, 32'h9ABCDEF0);
    chk("mtlo_hi", hi, 32'h12345678);

    for (int k = 0; k < 13; k++) begin
      do_op($sformatf("vec%0d", k), tbl[k]);
    end

    start   = 1'b1;
    op      = MULTU;
    rs_data = 32'd9;
    rt_data = 32'd9;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (11) @(negedge clk);
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_hi", hi, 32'd0);
    chk("midrst_lo", lo, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_op("post_rst", '{MULTU, 32'd3, 32'd5, 32'd0, 32'd15, -1, -1});

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmiss);
    $finish;
  end

endmodule
